// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Round-robin arbiter that serialises icache/dcache line fills
//                and write-backs onto one 128-bit memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int BE_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_inst_addr,
    input  logic [BE_W-1:0]   i_inst_byte_en,
    input  logic [DATA_W-1:0] i_inst_writedata,
    input  logic              i_inst_read,
    input  logic              i_inst_write,
    output logic [DATA_W-1:0] o_inst_readdata,
    output logic              o_inst_readdata_valid,
    output logic              o_inst_waitrequest,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [BE_W-1:0]   i_data_byte_en,
    input  logic [DATA_W-1:0] i_data_writedata,
    input  logic              i_data_read,
    input  logic              i_data_write,
    output logic [DATA_W-1:0] o_data_readdata,
    output logic              o_data_readdata_valid,
    output logic              o_data_waitrequest,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [BE_W-1:0]   o_mem_byte_en,
    output logic [DATA_W-1:0] o_mem_writedata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_readdata,
    input  logic              i_mem_readdata_valid,
    input  logic              i_mem_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_REQ  = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    localparam logic c_INST = 1'b0;
    localparam logic c_DATA = 1'b1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_grant;
    logic              r_owner;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [BE_W-1:0]   r_mem_byte_en;
    logic [DATA_W-1:0] r_mem_writedata;
    logic [DATA_W-1:0] r_inst_readdata;
    logic [DATA_W-1:0] r_data_readdata;
    logic              r_inst_valid;
    logic              r_data_valid;

    logic              w_inst_req;
    logic              w_data_req;
    logic              w_accept;
    logic              w_winner;
    logic              w_win_write;
    logic              w_rsp;

    assign w_inst_req  = i_inst_read | i_inst_write;
    assign w_data_req  = i_data_read | i_data_write;
    // Write wins over read when a master raises both.
    assign w_win_write = (w_winner == c_DATA) ? i_data_write : i_inst_write;
    assign w_rsp       = (r_state == S_RD_WAIT) & i_mem_readdata_valid;

    always_comb begin
        w_accept = 1'b0;
        w_winner = c_INST;
        if (r_state == S_IDLE) begin
            if (w_inst_req && (!w_data_req || r_last_grant == c_DATA)) begin
                w_accept = 1'b1;
                w_winner = c_INST;
            end else if (w_data_req) begin
                w_accept = 1'b1;
                w_winner = c_DATA;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_next = w_win_write ? S_WR : S_RD_REQ;
            S_WR:      if (!i_mem_waitrequest) w_state_next = S_IDLE;
            S_RD_REQ:  if (!i_mem_waitrequest) w_state_next = S_RD_WAIT;
            S_RD_WAIT: if (i_mem_readdata_valid) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant    <= c_DATA;
            r_owner         <= c_INST;
            r_mem_addr      <= '0;
            r_mem_byte_en   <= '0;
            r_mem_writedata <= '0;
            r_inst_readdata <= '0;
            r_data_readdata <= '0;
            r_inst_valid    <= 1'b0;
            r_data_valid    <= 1'b0;
        end else begin
            r_inst_valid <= w_rsp & (r_owner == c_INST);
            r_data_valid <= w_rsp & (r_owner == c_DATA);
            if (w_rsp && r_owner == c_INST) r_inst_readdata <= i_mem_readdata;
            if (w_rsp && r_owner == c_DATA) r_data_readdata <= i_mem_readdata;
            if (w_accept) begin
                r_last_grant    <= w_winner;
                r_owner         <= w_winner;
                r_mem_addr      <= (w_winner == c_DATA) ? i_data_addr      : i_inst_addr;
                r_mem_byte_en   <= (w_winner == c_DATA) ? i_data_byte_en   : i_inst_byte_en;
                r_mem_writedata <= (w_winner == c_DATA) ? i_data_writedata : i_inst_writedata;
            end
        end
    end

    // Command strobes decode the state register so they fall with rst.
    assign o_mem_read            = (r_state == S_RD_REQ);
    assign o_mem_write           = (r_state == S_WR);
    assign o_mem_addr            = r_mem_addr;
    assign o_mem_byte_en         = r_mem_byte_en;
    assign o_mem_writedata       = r_mem_writedata;
    assign o_inst_readdata       = r_inst_readdata;
    assign o_data_readdata       = r_data_readdata;
    assign o_inst_readdata_valid = r_inst_valid;
    assign o_data_readdata_valid = r_data_valid;
    assign o_inst_waitrequest    = rst | ~(w_accept & (w_winner == c_INST));
    assign o_data_waitrequest    = rst | ~(w_accept & (w_winner == c_DATA));

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Self-checking bench: arbitration table, directed corner
//                sequences and randomized traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  i_inst_addr, i_data_addr;
    logic [15:0]  i_inst_byte_en, i_data_byte_en;
    logic [127:0] i_inst_writedata, i_data_writedata;
    logic         i_inst_read, i_inst_write, i_data_read, i_data_write;
    logic [127:0] o_inst_readdata, o_data_readdata;
    logic         o_inst_readdata_valid, o_data_readdata_valid;
    logic         o_inst_waitrequest, o_data_waitrequest;
    logic [31:0]  o_mem_addr;
    logic [15:0]  o_mem_byte_en;
    logic [127:0] o_mem_writedata;
    logic         o_mem_read, o_mem_write;
    logic [127:0] i_mem_readdata;
    logic         i_mem_readdata_valid, i_mem_waitrequest;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(128), .BE_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_inst_addr(i_inst_addr), .i_inst_byte_en(i_inst_byte_en),
        .i_inst_writedata(i_inst_writedata), .i_inst_read(i_inst_read),
        .i_inst_write(i_inst_write), .o_inst_readdata(o_inst_readdata),
        .o_inst_readdata_valid(o_inst_readdata_valid),
        .o_inst_waitrequest(o_inst_waitrequest),
        .i_data_addr(i_data_addr), .i_data_byte_en(i_data_byte_en),
        .i_data_writedata(i_data_writedata), .i_data_read(i_data_read),
        .i_data_write(i_data_write), .o_data_readdata(o_data_readdata),
        .o_data_readdata_valid(o_data_readdata_valid),
        .o_data_waitrequest(o_data_waitrequest),
        .o_mem_addr(o_mem_addr), .o_mem_byte_en(o_mem_byte_en),
        .o_mem_writedata(o_mem_writedata), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .i_mem_readdata(i_mem_readdata),
        .i_mem_readdata_valid(i_mem_readdata_valid),
        .i_mem_waitrequest(i_mem_waitrequest)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_inst_addr = '0; i_inst_byte_en = '0; i_inst_writedata = '0;
        i_inst_read = 1'b0; i_inst_write = 1'b0;
        i_data_addr = '0; i_data_byte_en = '0; i_data_writedata = '0;
        i_data_read = 1'b0; i_data_write = 1'b0;
        i_mem_readdata = '0; i_mem_readdata_valid = 1'b0; i_mem_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_iwait", o_inst_waitrequest, 1);
        chk("rst_dwait", o_data_waitrequest, 1);
        chk("rst_mem_cmd", {o_mem_read, o_mem_write}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valids", {o_inst_readdata_valid, o_data_readdata_valid}, 0);
        chk("rst_rdata", o_inst_readdata | o_data_readdata, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
    endtask

    typedef struct {
        bit ird, iwr, drd, dwr;
        bit iw, dw, mrd, mwr, sel_d;
    } vec_t;
    vec_t vecs[6];

    // reference model state
    typedef struct {
        logic [31:0]  addr;
        logic [15:0]  be;
        logic [127:0] wd;
        bit           wr;
        int           own;
    } txn_t;
    txn_t         m_cur;
    int           m_phase;   // 0 free, 1 command on memory bus, 2 awaiting read data
    int           m_last;
    int           m_pulse;
    logic [127:0] m_rd [2];

    initial begin
        idle_inputs();
        vecs[0] = '{0,0,0,0, 1,1, 0,0, 0};
        vecs[1] = '{1,0,0,0, 0,1, 1,0, 0};
        vecs[2] = '{0,0,0,1, 1,0, 0,1, 1};
        vecs[3] = '{1,0,1,0, 0,1, 1,0, 0};
        vecs[4] = '{0,0,1,1, 1,0, 0,1, 1};
        vecs[5] = '{0,1,1,0, 0,1, 0,1, 0};

        // arbitration table, each from reset (inst wins first tie)
        for (int k = 0; k < 6; k++) begin
            do_reset();
            @(negedge clk);
            i_inst_addr = 32'h1000 + 32'(k); i_data_addr = 32'h2000 + 32'(k);
            i_inst_byte_en = 16'h00FF; i_data_byte_en = 16'hFF00;
            i_inst_read = vecs[k].ird; i_inst_write = vecs[k].iwr;
            i_data_read = vecs[k].drd; i_data_write = vecs[k].dwr;
            i_mem_waitrequest = 1'b1;
            #1;
            chk("tbl_iwait", o_inst_waitrequest, vecs[k].iw);
            chk("tbl_dwait", o_data_waitrequest, vecs[k].dw);
            @(negedge clk);
            i_inst_read = 0; i_inst_write = 0; i_data_read = 0; i_data_write = 0;
            #1;
            chk("tbl_mrd", o_mem_read, vecs[k].mrd);
            chk("tbl_mwr", o_mem_write, vecs[k].mwr);
            if (vecs[k].mrd | vecs[k].mwr) begin
                chk("tbl_addr", o_mem_addr, vecs[k].sel_d ? 32'h2000 + 32'(k) : 32'h1000 + 32'(k));
                chk("tbl_be", o_mem_byte_en, vecs[k].sel_d ? 16'hFF00 : 16'h00FF);
            end
        end

        // single icache read with one-cycle memory latency
        do_reset();
        @(negedge clk);
        i_inst_read = 1; i_inst_addr = 32'h40;
        #1;
        chk("rd_c0_iwait", o_inst_waitrequest, 0);
        @(negedge clk);
        i_inst_read = 0;
        #1;
        chk("rd_c1_mrd", o_mem_read, 1);
        chk("rd_c1_addr", o_mem_addr, 32'h40);
        @(negedge clk);
        i_mem_readdata = 128'hDEADBEEF_01234567_89ABCDEF_00112233;
        i_mem_readdata_valid = 1;
        #1;
        chk("rd_c2_mrd", o_mem_read, 0);
        @(negedge clk);
        i_mem_readdata_valid = 0;
        #1;
        chk("rd_c3_ivalid", o_inst_readdata_valid, 1);
        chk("rd_c3_idata", o_inst_readdata, 128'hDEADBEEF_01234567_89ABCDEF_00112233);
        chk("rd_c3_dvalid", o_data_readdata_valid, 0);
        @(negedge clk);
        #1;
        chk("rd_c4_ivalid", o_inst_readdata_valid, 0);

        // dcache write stalled by memory for 4 cycles
        do_reset();
        @(negedge clk);
        i_data_write = 1; i_data_addr = 32'h80; i_data_byte_en = 16'hFFFF;
        i_data_writedata = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        i_mem_waitrequest = 1;
        #1;
        chk("st_accept", o_data_waitrequest, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            i_data_addr = 32'h90; i_data_writedata = '1;
            i_mem_waitrequest = (c < 5);
            #1;
            chk("st_mwr", o_mem_write, 1);
            chk("st_addr", o_mem_addr, 32'h80);
            chk("st_be", o_mem_byte_en, 16'hFFFF);
            chk("st_wd", o_mem_writedata, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
            chk("st_dwait", o_data_waitrequest, 1);
        end
        @(negedge clk);
        i_data_write = 0;
        #1;
        chk("st_done", o_mem_write, 0);

        // reset asserted while waiting for read data
        do_reset();
        @(negedge clk);
        i_inst_read = 1; i_inst_addr = 32'h300;
        @(negedge clk);
        i_inst_read = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("rw_mrd", o_mem_read, 0);
        chk("rw_waits", {o_inst_waitrequest, o_data_waitrequest}, 2'b11);
        @(negedge clk);
        rst = 0; i_mem_readdata = '1; i_mem_readdata_valid = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            i_mem_readdata_valid = 0;
            #1;
            chk("rw_no_valid", {o_inst_readdata_valid, o_data_readdata_valid}, 0);
        end
        i_data_read = 1;
        #1;
        chk("rw_idle", o_data_waitrequest, 0);

        // stray memory valid while idle
        do_reset();
        @(negedge clk);
        i_mem_readdata = '1; i_mem_readdata_valid = 1;
        @(negedge clk);
        @(negedge clk);
        i_mem_readdata_valid = 0;
        #1;
        chk("stray_valid", {o_inst_readdata_valid, o_data_readdata_valid}, 0);
        chk("stray_rdata", o_inst_readdata | o_data_readdata, 0);

        // randomized traffic against the reference model
        do_reset();
        m_phase = 0; m_last = 1; m_pulse = -1; m_rd[0] = '0; m_rd[1] = '0;
        for (int n = 0; n < 3000; n++) begin
            int  win;
            bit  req_i, req_d;
            @(negedge clk);
            i_inst_read  = ($urandom_range(0, 2) == 0);
            i_inst_write = ($urandom_range(0, 3) == 0);
            i_data_read  = ($urandom_range(0, 2) == 0);
            i_data_write = ($urandom_range(0, 3) == 0);
            i_inst_addr = $urandom; i_data_addr = $urandom;
            i_inst_byte_en = 16'($urandom); i_data_byte_en = 16'($urandom);
            i_inst_writedata = {$urandom, $urandom, $urandom, $urandom};
            i_data_writedata = {$urandom, $urandom, $urandom, $urandom};
            i_mem_waitrequest = ($urandom_range(0, 2) == 0);
            i_mem_readdata_valid = ($urandom_range(0, 3) == 0);
            i_mem_readdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            req_i = i_inst_read | i_inst_write;
            req_d = i_data_read | i_data_write;
            win = -1;
            if (m_phase == 0) begin
                if (req_i && (!req_d || m_last == 1)) win = 0;
                else if (req_d) win = 1;
            end
            chk("rnd_iwait", o_inst_waitrequest, win != 0);
            chk("rnd_dwait", o_data_waitrequest, win != 1);
            chk("rnd_mrd", o_mem_read, m_phase == 1 && !m_cur.wr);
            chk("rnd_mwr", o_mem_write, m_phase == 1 && m_cur.wr);
            if (m_phase == 1) begin
                chk("rnd_addr", o_mem_addr, m_cur.addr);
                chk("rnd_be", o_mem_byte_en, m_cur.be);
                if (m_cur.wr) chk("rnd_wd", o_mem_writedata, m_cur.wd);
            end
            chk("rnd_ivalid", o_inst_readdata_valid, m_pulse == 0);
            chk("rnd_dvalid", o_data_readdata_valid, m_pulse == 1);
            chk("rnd_irdata", o_inst_readdata, m_rd[0]);
            chk("rnd_drdata", o_data_readdata, m_rd[1]);
            // inputs stay stable through the coming edge
            m_pulse = -1;
            if (m_phase == 0 && win >= 0) begin
                m_cur.own  = win;
                m_cur.addr = (win == 1) ? i_data_addr : i_inst_addr;
                m_cur.be   = (win == 1) ? i_data_byte_en : i_inst_byte_en;
                m_cur.wd   = (win == 1) ? i_data_writedata : i_inst_writedata;
                m_cur.wr   = (win == 1) ? i_data_write : i_inst_write;
                m_last     = win;
                m_phase    = 1;
            end else if (m_phase == 1 && !i_mem_waitrequest) begin
                m_phase = m_cur.wr ? 0 : 2;
            end else if (m_phase == 2 && i_mem_readdata_valid) begin
                m_rd[m_cur.own] = i_mem_readdata;
                m_pulse = m_cur.own;
                m_phase = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
